// File: rtl/fsm_state_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_state_monitor_pkg
//  Description : Shared types and helpers for the FSM state monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package fsm_state_monitor_pkg;

    // Monitor phase: no sample yet, tracking legal history, or latched fault.
    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_TRACK = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_t;

    // Increment that stops at (and never passes) the given ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] ceiling);
        return (value >= ceiling) ? ceiling : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_state_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_state_monitor_if
//  Description : Sample bus from the monitored FSM into the state monitor.
//  Revision    : 1.0  initial release
// ============================================================================
interface fsm_state_monitor_if #(
    parameter int STATE_W = 2
) ();
    logic               valid_in;
    logic [STATE_W-1:0] state_in;

    modport master (output valid_in, output state_in);
    modport slave  (input  valid_in, input  state_in);
endinterface
`default_nettype wire

// File: rtl/fsm_state_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_state_monitor_sat_counter
//  Description : Counter with clear, load-to-one and a runtime ceiling at
//                which it saturates; flags when it sits at the ceiling.
//  Revision    : 1.0  initial release
// ============================================================================
module fsm_state_monitor_sat_counter
    import fsm_state_monitor_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_load_one,
    input  wire logic             i_inc,
    input  wire logic [CNT_W-1:0] i_ceiling,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_sat
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear beats load, load beats increment.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load_one) begin
            count_d = CNT_W'(1);
        end else if (i_inc) begin
            count_d = CNT_W'(sat_inc(32'(count_q), 32'(i_ceiling)));
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_sat   = (count_q == i_ceiling);

endmodule
`default_nettype wire

// File: rtl/fsm_state_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_state_monitor
//  Description : Runtime checker on an encoded FSM state: illegal encodings,
//                visited coverage, stuck detection, saturating transitions.
//  Revision    : 1.0  initial release
// ============================================================================
module fsm_state_monitor
    import fsm_state_monitor_pkg::*;
#(
    parameter int STATE_W     = 2,
    parameter int NUM_STATES  = 3,
    parameter int CNT_W       = 8,
    parameter int STUCK_LIMIT = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    fsm_state_monitor_if.slave         mon_if,
    input  wire logic                  clear,
    output logic                       illegal,
    output logic [STATE_W-1:0]         illegal_state,
    output logic [(2**STATE_W)-1:0]    visited,
    output logic                       all_visited,
    output logic [CNT_W-1:0]           trans_count,
    output logic                       trans_sat,
    output logic                       stuck
);

    localparam int c_num_enc = 2**STATE_W;
    localparam logic [c_num_enc-1:0] c_vis_mask =
        c_num_enc'((65'(1) << NUM_STATES) - 65'(1));

    mon_state_t            state_d,         state_q;
    logic [STATE_W-1:0]    last_state_d,    last_state_q;
    logic [c_num_enc-1:0]  visited_d,       visited_q;
    logic                  illegal_d,       illegal_q;
    logic [STATE_W-1:0]    illegal_state_d, illegal_state_q;

    logic                  w_sample;
    logic                  w_illegal_in;
    logic                  w_active;
    logic                  w_changed;
    logic [CNT_W-1:0]      w_run_len;

    // A sample coinciding with clear is discarded.
    assign w_sample     = mon_if.valid_in && !clear;
    assign w_illegal_in = (32'(mon_if.state_in) >= 32'(NUM_STATES));
    assign w_active     = (state_q != MON_IDLE);
    assign w_changed    = (mon_if.state_in != last_state_q);

    // Next-state and sticky-result logic of the monitor.
    always_comb begin
        state_d         = state_q;
        last_state_d    = last_state_q;
        visited_d       = visited_q;
        illegal_d       = illegal_q;
        illegal_state_d = illegal_state_q;
        if (clear) begin
            state_d         = MON_IDLE;
            last_state_d    = '0;
            visited_d       = '0;
            illegal_d       = 1'b0;
            illegal_state_d = '0;
        end else if (mon_if.valid_in) begin
            visited_d[mon_if.state_in] = 1'b1;
            last_state_d               = mon_if.state_in;
            // Only the first illegal encoding is kept; FAULT is terminal.
            if (w_illegal_in && (state_q != MON_FAULT)) begin
                illegal_d       = 1'b1;
                illegal_state_d = mon_if.state_in;
            end
            case (state_q)
                MON_IDLE:  state_d = w_illegal_in ? MON_FAULT : MON_TRACK;
                MON_TRACK: state_d = w_illegal_in ? MON_FAULT : MON_TRACK;
                MON_FAULT: state_d = MON_FAULT;
                default:   state_d = MON_IDLE;
            endcase
        end
    end

    // Monitor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= MON_IDLE;
            last_state_q    <= '0;
            visited_q       <= '0;
            illegal_q       <= 1'b0;
            illegal_state_q <= '0;
        end else begin
            state_q         <= state_d;
            last_state_q    <= last_state_d;
            visited_q       <= visited_d;
            illegal_q       <= illegal_d;
            illegal_state_q <= illegal_state_d;
        end
    end

    // Transition count: the first sample after IDLE is never a transition.
    fsm_state_monitor_sat_counter #(.CNT_W(CNT_W)) u_trans_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clear),
        .i_load_one (1'b0),
        .i_inc      (w_sample && w_active && w_changed),
        .i_ceiling  ({CNT_W{1'b1}}),
        .o_count    (trans_count),
        .o_sat      (trans_sat)
    );

    // Run length of the current state; restarts at 1 on any new state.
    fsm_state_monitor_sat_counter #(.CNT_W(CNT_W)) u_run_len (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clear),
        .i_load_one (w_sample && (!w_active || w_changed)),
        .i_inc      (w_sample && w_active && !w_changed),
        .i_ceiling  (CNT_W'(STUCK_LIMIT)),
        .o_count    (w_run_len),
        .o_sat      (stuck)
    );

    assign illegal       = illegal_q;
    assign illegal_state = illegal_state_q;
    assign visited       = visited_q;
    assign all_visited   = ((visited_q & c_vis_mask) == c_vis_mask);

endmodule
`default_nettype wire
